// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by fetch_unit and fetch_pc_next.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pc_next.sv
// Next fetch address select: hold, advance one word, or redirect.
// Redirect targets are forced word aligned.
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] pc_i,
    input  logic         inc_i,
    input  logic         redir_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic [N-1:0] pc_next_o
);

    logic unused_lsb;
    assign unused_lsb = ^redirect_pc_i[1:0];

    // Redirect wins over increment; increment wraps modulo 2^N.
    always_comb begin
        pc_next_o = pc_i;
        if (redir_i) begin
            pc_next_o = {redirect_pc_i[N-1:2], 2'b00};
        end else if (inc_i) begin
            pc_next_o = pc_i + N'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with stall and redirect.
// Holds the fetch pc, the output register and the IDLE/REQ/WAIT FSM.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic         instr_valid,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc
);

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         discard_q, discard_d;
    logic         valid_q, valid_d;
    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] ipc_q, ipc_d;
    logic         pc_inc, pc_redir;
    logic         req;
    logic         consumed;

    fetch_pc_next #(.N(N)) u_pc_next (
        .pc_i          (pc_q),
        .inc_i         (pc_inc),
        .redir_i       (pc_redir),
        .redirect_pc_i (redirect_pc),
        .pc_next_o     (pc_d)
    );

    assign consumed    = valid_q & ~stall;
    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;

    // Next state, request and output-register update.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        pc_inc    = 1'b0;
        pc_redir  = 1'b0;
        req       = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    pc_redir = 1'b1;
                    valid_d  = 1'b0;
                end else begin
                    req = ~valid_q | ~stall;
                    if (consumed) valid_d = 1'b0;
                    if (req && imem_ready) state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d   = REQ;
                    discard_d = 1'b0;
                    if (redirect) begin
                        pc_redir = 1'b1;
                        valid_d  = 1'b0;
                    end else if (discard_q) begin
                        if (consumed) valid_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_inc  = 1'b1;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                    pc_redir  = 1'b1;
                    valid_d   = 1'b0;
                end else if (consumed) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; clr abandons any outstanding fetch.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            ipc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a transaction-level model
// checked every cycle plus literal expectations at key points.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(.N(32), .RESET_PC(32'h100)) dut (
        .clk         (clk),
        .clr         (clr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // memory responder state
    int          lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    bit          acc_last = 0;
    logic [31:0] addr_last = '0;
    logic [31:0] acc_log[$];

    // model of the fetch unit at transaction level
    bit          m_on = 0;
    bit          m_out = 0;
    bit          m_drop = 0;
    bit          m_v = 0;
    logic [31:0] m_pc = 32'h100;
    logic [31:0] m_i = '0;
    logic [31:0] m_ipc = '0;

    always @(negedge clk) begin : compare
        bit er;
        if (clr) begin
            m_on = 0; m_out = 0; m_drop = 0; m_v = 0;
            m_pc = 32'h100; m_i = '0; m_ipc = '0;
        end
        er = m_on && !m_out && !redirect && (!m_v || !stall);
        chk("req", {31'b0, imem_req}, {31'b0, er});
        chk("addr", imem_addr, m_pc);
        chk("valid", {31'b0, instr_valid}, {31'b0, m_v});
        chk("instr", instr, m_i);
        chk("instr_pc", instr_pc, m_ipc);
        acc_last  = imem_req & imem_ready;
        addr_last = imem_addr;
        if (acc_last) acc_log.push_back(imem_addr);
        if (!clr) begin
            if (!m_on) begin
                m_on = 1;
            end else if (!m_out) begin
                if (redirect) begin
                    m_pc = redirect_pc & ~32'h3;
                    m_v  = 0;
                end else begin
                    if (m_v && !stall) m_v = 0;
                    if (er && imem_ready) m_out = 1;
                end
            end else if (imem_rvalid) begin
                m_out = 0;
                if (redirect) begin
                    m_drop = 0;
                    m_pc   = redirect_pc & ~32'h3;
                    m_v    = 0;
                end else if (m_drop) begin
                    m_drop = 0;
                    if (m_v && !stall) m_v = 0;
                end else begin
                    m_i   = imem_rdata;
                    m_ipc = m_pc;
                    m_v   = 1;
                    m_pc  = m_pc + 32'd4;
                end
            end else if (redirect) begin
                m_drop = 1;
                m_pc   = redirect_pc & ~32'h3;
                m_v    = 0;
            end else if (m_v && !stall) begin
                m_v = 0;
            end
        end
    end

    task automatic step(input bit st = 0, input bit rd = 0,
                        input logic [31:0] rp = '0,
                        input bit rdy = 1, input bit c = 0);
        @(posedge clk);
        #1;
        if (acc_last) begin
            pend_cnt  = lat;
            pend_addr = addr_last;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(pend_addr);
            end
        end
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        imem_ready  = rdy;
        clr         = c;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step(.c(1));
        at_neg;
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        step();
        at_neg;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        step();
        at_neg;
        chk("f0_addr", imem_addr, 32'h100);
        chk("f0_req", {31'b0, imem_req}, 32'd1);
        step();
        step();
        at_neg;
        chk("f0_ipc", instr_pc, 32'h100);
        chk("f0_instr", instr, word(32'h100));
        chk("f1_addr", imem_addr, 32'h104);
        step(.st(1));
        step(.st(1));
        at_neg;
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_ipc", instr_pc, 32'h104);
        chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        step(.st(1));
        at_neg;
        chk("stall_hold_ipc", instr_pc, 32'h104);
        chk("stall_hold_req", {31'b0, imem_req}, 32'd0);
        step();
        at_neg;
        chk("rel_addr", imem_addr, 32'h108);
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        step();
        step();
        at_neg;
        chk("f2_ipc", instr_pc, 32'h108);
        lat = 3;
        step(.rd(1), .rp(32'h203));
        step();
        at_neg;
        chk("rd_valid", {31'b0, instr_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h200);
        step();
        at_neg;
        chk("drop_valid", {31'b0, instr_valid}, 32'd0);
        chk("drop_req", {31'b0, imem_req}, 32'd0);
        step();
        at_neg;
        chk("rd_new_addr", imem_addr, 32'h200);
        chk("rd_new_req", {31'b0, imem_req}, 32'd1);
        lat = 1;
        step();
        step();
        at_neg;
        chk("t200_ipc", instr_pc, 32'h200);
        chk("t200_instr", instr, word(32'h200));
        step(.rd(1), .rp(32'h30A));
        step();
        at_neg;
        chk("same_addr", imem_addr, 32'h308);
        chk("same_valid", {31'b0, instr_valid}, 32'd0);
        step();
        step(.rd(1), .rp(32'hFFFF_FFFF));
        at_neg;
        chk("t308_ipc", instr_pc, 32'h308);
        chk("redir_req_low", {31'b0, imem_req}, 32'd0);
        step();
        at_neg;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        at_neg;
        chk("top_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);
        step();
        step();
        lat = 4;
        step(.c(1));
        at_neg;
        chk("clr_addr", imem_addr, 32'h100);
        chk("clr_valid", {31'b0, instr_valid}, 32'd0);
        step();
        at_neg;
        chk("clr_idle_req", {31'b0, imem_req}, 32'd0);
        step(.rdy(0));
        step(.rdy(0));
        at_neg;
        chk("late_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_addr", imem_addr, 32'h100);
        lat = 1;
        step();
        at_neg;
        chk("clr_fetch_req", {31'b0, imem_req}, 32'd1);
        step();
        step();
        at_neg;
        chk("clr_ipc", instr_pc, 32'h100);
        chk("clr_instr", instr, word(32'h100));
        lat = 2;
        for (int i = 0; i < 24; i++) begin
            step(.st(i % 3 == 0), .rdy(i % 5 != 1));
        end
        step();
        at_neg;
        if (acc_log.size() >= 3) begin
            chk("acc0", acc_log[0], 32'h100);
            chk("acc1", acc_log[1], 32'h104);
            chk("acc2", acc_log[2], 32'h108);
        end else begin
            chk("acc_count", acc_log.size(), 32'd3);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, default 32, SHALL set the address/instruction width.
REQ-002 Parameter RESET_PC, default 0, SHALL set the fetch address loaded on reset.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 clr  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 stall  in  1  SHALL mean the downstream stage cannot accept the presented instruction.
REQ-006 redirect  in  1  SHALL mean a branch/jump target is presented; flush and refetch from it.
REQ-007 redirect_pc  in  N  SHALL be the redirect target; bits [1:0] ignored, treated as 00.
REQ-008 imem_req  out  1  SHALL be the instruction-memory request valid.
REQ-009 imem_addr  out  N  SHALL be the request address, always equal to the internal fetch pc.
REQ-010 imem_ready  in  1  SHALL mean memory accepts; a request is accepted iff imem_req & imem_ready in the same cycle.
REQ-011 imem_rvalid  in  1  SHALL mark imem_rdata valid; exactly one per accepted request, at least one cycle after acceptance.
REQ-012 imem_rdata  in  N  SHALL be the returned instruction word.
REQ-013 instr_valid  out  1  SHALL mark instr/instr_pc valid; consumed when instr_valid & !stall.
REQ-014 instr  out  N  SHALL be the fetched instruction word.
REQ-015 instr_pc  out  N  SHALL be the address instr was fetched from.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT; at most one request outstanding.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 In REQ, imem_req SHALL be 1 iff !redirect and (!instr_valid | !stall); otherwise 0.
REQ-019 REQ -> WAIT SHALL occur on acceptance (imem_req & imem_ready); otherwise stay in REQ.
REQ-020 In WAIT, on imem_rvalid with discard=0 and redirect=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to REQ.
REQ-021 Response-to-output latency SHALL be one cycle: rvalid in cycle t -> instr_valid high in cycle t+1.
REQ-022 pc+4 SHALL wrap modulo 2^N (all-ones-minus-3 -> 0).
REQ-023 instr_valid SHALL clear on consumption unless a new instruction loads in the same cycle; with stall=1 all outputs SHALL hold.
REQ-024 redirect in any state other than IDLE SHALL set pc<=redirect_pc & ~3 and clear instr_valid in the next cycle, overriding stall.
REQ-025 redirect in REQ SHALL keep the state in REQ, with the new request issued the following cycle.
REQ-026 redirect in WAIT without rvalid SHALL set discard<=1 and stay in WAIT.
REQ-027 In WAIT, rvalid with discard=1 or redirect=1 SHALL drop the response, clear discard, and go to REQ.
REQ-028 redirect in IDLE SHALL be ignored.
REQ-029 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-030 While clr=1: state=IDLE, pc=RESET_PC, discard=0, instr_valid=0, instr=0, instr_pc=0, imem_req=0, imem_addr=RESET_PC.
REQ-031 clr asserted mid-transaction SHALL abandon the outstanding request; a late rvalid after release SHALL be ignored per REQ-029.

Structure
REQ-032 A package fetch_pkg SHALL hold the FSM state enum and constant INSTR_BYTES=4.
REQ-033 The pc/discard/output registers and FSM SHALL live in fetch_unit; sub-module fetch_pc_next (combinational next-pc select: hold, +4, or redirect) is permitted.

Verification
REQ-034 Reset release, RESET_PC=0x100, imem_ready=1, rvalid 1 cycle after each accept -> imem_addr 0x100, 0x104, 0x108; instr_pc matches each, instr_valid pulses.
REQ-035 stall=1 while instr_valid=1 (instr_pc=0x104) -> imem_req=0, outputs stable; stall released -> fetch 0x108 issued.
REQ-036 redirect=1, redirect_pc=0x203 in WAIT, rvalid 2 cycles later -> response dropped, instr_valid=0, next imem_addr=0x200.
REQ-037 redirect and rvalid in the same WAIT cycle -> data dropped, next request 0x200-aligned target.
REQ-038 pc=0xFFFFFFFC fetch completes -> next imem_addr=0x00000000.
REQ-039 clr pulsed in WAIT, rvalid arrives after release -> ignored; first fetch from RESET_PC.
